// File: rtl/mfp_adc_max10_responder_pkg.sv
// rtl/mfp_adc_max10_responder_pkg.sv - ADC constants shared by the MAX10 ADC responder
//
// Purpose: channel/data widths, channel codes, default channel mask,
//          command record and framing-state type.
// Ports:   none (package).
package mfp_adc_max10_responder_pkg;

  localparam int CH_W   = 5;
  localparam int DATA_W = 12;

  localparam logic [CH_W-1:0] CH_T    = 5'd31;  // temperature sensor
  localparam logic [CH_W-1:0] CH_NONE = 5'd0;   // shown on sample_channel when idle

  // Channels 0..16 plus the temperature sensor.
  localparam logic [31:0] DEF_CH_MASK = 32'h8001_FFFF;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            sop;
    logic            eop;
  } adc_cmd_t;

  typedef enum logic {
    S_OUT = 1'b0,
    S_IN  = 1'b1
  } frame_state_t;

  function automatic logic ch_implemented(input logic [31:0] mask, input logic [CH_W-1:0] ch);
    return mask[ch];
  endfunction

endpackage

// File: rtl/mfp_adc_max10_responder_adc_cmd_framer.sv
// rtl/mfp_adc_max10_responder_adc_cmd_framer.sv - SOP/EOP framing checker for accepted commands
//
// Purpose: tracks whether the command stream is inside a packet and pulses
//          err for a missing SOP outside a packet or a SOP inside one.
// Ports:   CLK, RESETn (sync, active-low)
//          accept  - a command is handshaken this cycle
//          sop/eop - framing bits of that command
//          err     - combinational one-cycle error pulse
module mfp_adc_max10_responder_adc_cmd_framer
  import mfp_adc_max10_responder_pkg::*;
(
  input  logic CLK,
  input  logic RESETn,
  input  logic accept,
  input  logic sop,
  input  logic eop,
  output logic err
);

  frame_state_t state, state_next;

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= S_OUT;
    else         state <= state_next;
  end

  // In both error cases the offending command opens a new packet, so the
  // next state depends only on EOP once a command is accepted.
  always_comb begin
    state_next = state;
    err        = 1'b0;
    if (accept) begin
      case (state)
        S_OUT: begin
          err        = ~sop;
          state_next = eop ? S_OUT : S_IN;
        end
        S_IN: begin
          err        = sop;
          state_next = eop ? S_OUT : S_IN;
        end
        default: state_next = S_OUT;
      endcase
    end
  end

endmodule

// File: rtl/mfp_adc_max10_responder.sv
// rtl/mfp_adc_max10_responder.sv - behavioural stand-in for the MAX10 modular ADC hard block
//
// Purpose: accepts commands, converts each for CONV_CYCLES cycles using an
//          externally supplied sample, and returns one response beat each.
// Ports:   CLK, RESETn (sync, active-low)
//          ADC_C_*        - command stream in (Valid/Ready, Channel, SOP, EOP)
//          ADC_R_*        - response stream out (one-cycle Valid, no backpressure)
//          sample_channel - channel being converted (0 when idle)
//          sample_data    - sample for sample_channel, from outside
//          proto_err      - sticky framing / unimplemented-channel error
//          err_clr        - clears proto_err
module mfp_adc_max10_responder
  import mfp_adc_max10_responder_pkg::*;
#(
  parameter int          CONV_CYCLES    = 4,
  parameter int          STARTUP_CYCLES = 16,
  parameter logic [31:0] CH_MASK        = DEF_CH_MASK
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              ADC_C_Valid,
  input  logic [CH_W-1:0]   ADC_C_Channel,
  input  logic              ADC_C_SOP,
  input  logic              ADC_C_EOP,
  output logic              ADC_C_Ready,
  output logic              ADC_R_Valid,
  output logic [CH_W-1:0]   ADC_R_Channel,
  output logic [DATA_W-1:0] ADC_R_Data,
  output logic              ADC_R_SOP,
  output logic              ADC_R_EOP,
  output logic [CH_W-1:0]   sample_channel,
  input  logic [DATA_W-1:0] sample_data,
  output logic              proto_err,
  input  logic              err_clr
);

  // A command taken into an idle converter counts its accept cycle as the
  // first conversion cycle; a command entering behind another one gets a
  // full CONV_CYCLES window so responses stay CONV_CYCLES apart.
  localparam logic [7:0] CNT_FIRST = 8'(CONV_CYCLES - 2);
  localparam logic [7:0] CNT_FULL  = 8'(CONV_CYCLES - 1);
  localparam logic [7:0] CNT_START = 8'(STARTUP_CYCLES);

  logic [7:0] startup_cnt;
  adc_cmd_t   conv_cmd;
  logic       conv_valid;
  logic [7:0] conv_cnt;
  adc_cmd_t   pend_cmd;
  logic       pend_valid;

  adc_cmd_t   c_cmd;
  logic       accept;
  logic       conv_last;
  logic       load_direct;
  logic       frame_err;
  logic       ch_ok;

  assign c_cmd       = '{ch: ADC_C_Channel, sop: ADC_C_SOP, eop: ADC_C_EOP};
  assign ADC_C_Ready = (startup_cnt == 8'd0) && !pend_valid;
  assign accept      = ADC_C_Valid && ADC_C_Ready;
  assign conv_last   = conv_valid && (conv_cnt == 8'd0);
  assign load_direct = accept && (!conv_valid || (conv_last && !pend_valid));
  assign ch_ok       = ch_implemented(CH_MASK, conv_cmd.ch);

  assign sample_channel = conv_valid ? conv_cmd.ch : CH_NONE;

  mfp_adc_max10_responder_adc_cmd_framer u_framer (
    .CLK    (CLK),
    .RESETn (RESETn),
    .accept (accept),
    .sop    (ADC_C_SOP),
    .eop    (ADC_C_EOP),
    .err    (frame_err)
  );

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      startup_cnt   <= CNT_START;
      conv_cmd      <= '0;
      conv_valid    <= 1'b0;
      conv_cnt      <= 8'd0;
      pend_cmd      <= '0;
      pend_valid    <= 1'b0;
      ADC_R_Valid   <= 1'b0;
      ADC_R_Channel <= '0;
      ADC_R_Data    <= '0;
      ADC_R_SOP     <= 1'b0;
      ADC_R_EOP     <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      if (startup_cnt != 8'd0) startup_cnt <= startup_cnt - 8'd1;

      // Response beat is launched from the converter's last cycle.
      if (conv_last) begin
        ADC_R_Valid   <= 1'b1;
        ADC_R_Channel <= conv_cmd.ch;
        ADC_R_Data    <= ch_ok ? sample_data : '0;
        ADC_R_SOP     <= conv_cmd.sop;
        ADC_R_EOP     <= conv_cmd.eop;
      end else begin
        ADC_R_Valid   <= 1'b0;
        ADC_R_Channel <= '0;
        ADC_R_Data    <= '0;
        ADC_R_SOP     <= 1'b0;
        ADC_R_EOP     <= 1'b0;
      end

      // Converter stage. Ready is low whenever pending is full, so a new
      // accept never coincides with the pending-to-converter transfer.
      if (load_direct) begin
        conv_cmd   <= c_cmd;
        conv_valid <= 1'b1;
        conv_cnt   <= conv_valid ? CNT_FULL : CNT_FIRST;
      end else if (conv_last && pend_valid) begin
        conv_cmd   <= pend_cmd;
        conv_cnt   <= CNT_FULL;
        pend_valid <= 1'b0;
      end else if (conv_last) begin
        conv_valid <= 1'b0;
        conv_cmd   <= '0;
      end else if (conv_valid) begin
        conv_cnt   <= conv_cnt - 8'd1;
      end

      if (accept && !load_direct) begin
        pend_cmd   <= c_cmd;
        pend_valid <= 1'b1;
      end

      // Set has priority over clear.
      if (frame_err || (conv_last && !ch_ok)) proto_err <= 1'b1;
      else if (err_clr)                       proto_err <= 1'b0;
    end
  end

endmodule
